// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: entry layout, data word and default depth.
package reorder_buffer_pkg;

    localparam int ROB_DEPTH_DEF = 16;

    typedef logic [31:0] MemoryWord;

    typedef struct packed {
        logic       valid;
        logic       ready;
        logic       regwr;
        logic [4:0] dest;
        MemoryWord  value;
    } rob_entry;

endpackage

// File: rtl/reorder_buffer_rob_ptr.sv
// Wrapping index counter 0..DEPTH-1, used for the ROB head and tail.
module rob_ptr #(
    parameter int DEPTH = 16,
    parameter int IW    = 4
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          advance,
    output logic [IW-1:0] idx
);

    // Clear to slot 0, otherwise step and wrap from DEPTH-1 back to 0.
    always_ff @(posedge clk) begin
        if (clear)
            idx <= '0;
        else if (advance)
            idx <= (idx == IW'(DEPTH - 1)) ? '0 : idx + IW'(1);
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement reorder buffer. Tags are slot index + 1; tag 0 means none.
// Optional feature: define ROB_FLUSH_EN to add a synchronous flush input.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_DEPTH = ROB_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       reset,
`ifdef ROB_FLUSH_EN
    input  logic       flush,
`endif
    input  logic       alloc_valid,
    input  logic       alloc_regwr,
    input  logic [4:0] alloc_dest,
    output logic       alloc_ready,
    output int         alloc_tag,
    input  logic       wb_valid,
    input  int         wb_tag,
    input  rob_entry   wb_entry,
    input  int         rd_tag1,
    output rob_entry   rd_entry1,
    output logic       retire_valid,
    output int         retire_tag,
    output logic [4:0] retire_dest,
    output logic       retire_regwr,
    output MemoryWord  retire_value,
    output int         count
);

    localparam int IW = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1;
    localparam int CW = $clog2(ROB_DEPTH + 1);

    rob_entry        entries [ROB_DEPTH];
    logic [IW-1:0]   head;
    logic [IW-1:0]   tail;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   wb_idx;
    logic            flush_i;
    logic            clear;
    logic            wb_hit;
    logic            alloc_fire;
    logic            retire_fire;
    rob_entry        head_e;
    logic            unused_wb;

`ifdef ROB_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // Only value is taken from the writeback entry; the valid/ready state is owned here.
    assign unused_wb = ^{wb_entry.valid, wb_entry.ready, wb_entry.regwr, wb_entry.dest};

    assign clear       = reset | flush_i;
    assign head_e      = entries[head];
    assign wb_idx      = IW'(wb_tag - 1);
    assign wb_hit      = wb_valid && (wb_tag >= 1) && (wb_tag <= ROB_DEPTH) && entries[wb_idx].valid;
    // No full bypass: a retire in the same cycle does not free a slot for allocation.
    assign alloc_ready = (cnt < CW'(ROB_DEPTH));
    assign alloc_fire  = alloc_valid & alloc_ready & ~clear;
    assign retire_fire = head_e.valid & head_e.ready & ~clear;
    assign alloc_tag   = int'(tail) + 1;
    assign count       = int'(cnt);

    rob_ptr #(.DEPTH(ROB_DEPTH), .IW(IW)) u_head (
        .clk(clk), .clear(clear), .advance(retire_fire), .idx(head)
    );

    rob_ptr #(.DEPTH(ROB_DEPTH), .IW(IW)) u_tail (
        .clk(clk), .clear(clear), .advance(alloc_fire), .idx(tail)
    );

    // Entry storage: writeback marks ready, allocate fills the tail, retire frees the head.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < ROB_DEPTH; i++)
                entries[i] <= '0;
        end else begin
            if (wb_hit) begin
                entries[wb_idx].value <= wb_entry.value;
                entries[wb_idx].ready <= 1'b1;
            end
            if (alloc_fire)
                entries[tail] <= '{valid: 1'b1, ready: 1'b0, regwr: alloc_regwr,
                                   dest: alloc_dest, value: '0};
            if (retire_fire)
                entries[head].valid <= 1'b0;
        end
    end

    // Occupancy: allocate and retire in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (clear)
            cnt <= '0;
        else begin
            case ({alloc_fire, retire_fire})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Retire outputs show the head entry only while it is retiring, zero otherwise.
    always_comb begin
        retire_valid = retire_fire;
        retire_tag   = 0;
        retire_dest  = '0;
        retire_regwr = 1'b0;
        retire_value = '0;
        if (retire_fire) begin
            retire_tag   = int'(head) + 1;
            retire_dest  = head_e.dest;
            retire_regwr = head_e.regwr;
            retire_value = head_e.value;
        end
    end

    // Commit-stage lookup port; zero for tag 0 or out of range, no writeback bypass.
    always_comb begin
        rd_entry1 = '0;
        if (rd_tag1 >= 1 && rd_tag1 <= ROB_DEPTH)
            rd_entry1 = entries[IW'(rd_tag1 - 1)];
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer against a queue-based model of the ROB.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int D = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       alloc_valid = 1'b0;
    logic       alloc_regwr = 1'b0;
    logic [4:0] alloc_dest = '0;
    logic       alloc_ready;
    int         alloc_tag;
    logic       wb_valid = 1'b0;
    int         wb_tag = 0;
    rob_entry   wb_entry = '0;
    int         rd_tag1 = 0;
    rob_entry   rd_entry1;
    logic       retire_valid;
    int         retire_tag;
    logic [4:0] retire_dest;
    logic       retire_regwr;
    MemoryWord  retire_value;
    int         count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reorder_buffer #(.ROB_DEPTH(D)) dut (
        .clk(clk), .reset(reset),
`ifdef ROB_FLUSH_EN
        .flush(flush),
`endif
        .alloc_valid(alloc_valid), .alloc_regwr(alloc_regwr), .alloc_dest(alloc_dest),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_entry(wb_entry),
        .rd_tag1(rd_tag1), .rd_entry1(rd_entry1),
        .retire_valid(retire_valid), .retire_tag(retire_tag), .retire_dest(retire_dest),
        .retire_regwr(retire_regwr), .retire_value(retire_value), .count(count)
    );

    // Model: in-flight instructions in program order, plus the next tag to hand out.
    typedef struct {
        int         tag;
        logic       regwr;
        logic [4:0] dest;
        MemoryWord  value;
        bit         ready;
    } ment_t;

    ment_t q[$];
    int    next_tag = 1;

    function automatic bit m_retire();
        return (q.size() > 0) && q[0].ready;
    endfunction

    // Apply one cycle of inputs, advance the model, sample #1 after the edge with idle inputs.
    task automatic step(input bit rst, input bit fl, input bit av, input bit rw,
                        input logic [4:0] d, input bit wv, input int wt, input MemoryWord wval);
        bit ret;
        bit full;
        reset = rst; flush = fl; alloc_valid = av; alloc_regwr = rw; alloc_dest = d;
        wb_valid = wv; wb_tag = wt;
        wb_entry = '0; wb_entry.value = wval; wb_entry.dest = 5'($urandom); wb_entry.regwr = 1'($urandom);
        if (rst || fl) begin
            q.delete(); next_tag = 1;
        end else begin
            ret  = m_retire();
            full = (q.size() >= D);
            if (wv) foreach (q[i]) if (q[i].tag == wt) begin q[i].value = wval; q[i].ready = 1'b1; end
            if (ret) q.delete(0);
            if (av && !full) begin
                q.push_back('{tag: next_tag, regwr: rw, dest: d, value: 32'h0, ready: 1'b0});
                next_tag = next_tag % D + 1;
            end
        end
        @(posedge clk); #1;
        reset = 1'b0; flush = 1'b0; alloc_valid = 1'b0; wb_valid = 1'b0; wb_tag = 0;
    endtask

    task automatic idle(); step(0, 0, 0, 0, 5'd0, 0, 0, 32'h0); endtask
    task automatic alloc(input logic [4:0] d); step(0, 0, 1, 1, d, 0, 0, 32'h0); endtask
    task automatic wback(input int t, input MemoryWord v); step(0, 0, 0, 0, 5'd0, 1, t, v); endtask

    task automatic test_reset();
        step(1, 0, 1, 1, 5'd3, 1, 1, 32'hdead);
        reset = 1'b1; alloc_valid = 1'b1; wb_valid = 1'b1; wb_tag = 1;
        @(posedge clk); #1;
        checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL rst_rv got %b want 0", retire_valid); end
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", alloc_ready); end
        checks++; if (alloc_tag !== 1) begin errors++; $display("FAIL rst_tag got %0d want 1", alloc_tag); end
        checks++; if (count !== 0) begin errors++; $display("FAIL rst_count got %0d want 0", count); end
        checks++; if ({retire_tag, retire_dest, retire_regwr, retire_value} !== '0)
            begin errors++; $display("FAIL rst_retire_out got %0d/%0d/%b/%h want 0", retire_tag, retire_dest, retire_regwr, retire_value); end
        reset = 1'b0; alloc_valid = 1'b0; wb_valid = 1'b0;
        idle();
        checks++; if (count !== 0 || alloc_tag !== 1) begin errors++; $display("FAIL post_rst got count=%0d tag=%0d want 0/1", count, alloc_tag); end
    endtask

    task automatic test_fill();
        step(1, 0, 0, 0, 5'd0, 0, 0, 32'h0);
        for (int i = 0; i < D; i++) begin
            checks++; if (alloc_tag !== i + 1) begin errors++; $display("FAIL fill_tag got %0d want %0d", alloc_tag, i + 1); end
            alloc(5'(i));
        end
        checks++; if (count !== D) begin errors++; $display("FAIL fill_count got %0d want %0d", count, D); end
        checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b want 0", alloc_ready); end
        alloc(5'd31);
        checks++; if (count !== D || alloc_tag !== 1) begin errors++; $display("FAIL full_alloc got count=%0d tag=%0d want %0d/1", count, alloc_tag, D); end
        rd_tag1 = 1; #1;
        checks++; if (rd_entry1 !== rob_entry'{valid: 1'b1, ready: 1'b0, regwr: 1'b1, dest: 5'd0, value: 32'h0})
            begin errors++; $display("FAIL full_entry1 got %h want dest 0 valid entry", rd_entry1); end
        checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL full_rv got %b want 0", retire_valid); end
    endtask

    task automatic test_wb_order();
        step(1, 0, 0, 0, 5'd0, 0, 0, 32'h0);
        alloc(5'd1); alloc(5'd2); alloc(5'd3);
        wback(2, 32'h55);
        checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL order_early_rv got %b want 0", retire_valid); end
        wback(1, 32'h55);
        checks++; if (retire_valid !== 1'b1 || retire_tag !== 1 || retire_value !== 32'h55 || retire_dest !== 5'd1)
            begin errors++; $display("FAIL order_ret1 got v=%b t=%0d val=%h d=%0d want 1/1/55/1", retire_valid, retire_tag, retire_value, retire_dest); end
        idle();
        checks++; if (retire_valid !== 1'b1 || retire_tag !== 2 || retire_value !== 32'h55)
            begin errors++; $display("FAIL order_ret2 got v=%b t=%0d val=%h want 1/2/55", retire_valid, retire_tag, retire_value); end
        idle();
        checks++; if (retire_valid !== 1'b0 || count !== 1) begin errors++; $display("FAIL order_done got v=%b count=%0d want 0/1", retire_valid, count); end
    endtask

    task automatic test_full_alloc_retire();
        step(1, 0, 0, 0, 5'd0, 0, 0, 32'h0);
        for (int i = 1; i <= 4; i++) alloc(5'(i));
        for (int i = 1; i <= 4; i++) wback(i, MemoryWord'(i));
        for (int i = 0; i < 4; i++) idle();
        checks++; if (count !== 0 || alloc_tag !== 5) begin errors++; $display("FAIL head5 got count=%0d tag=%0d want 0/5", count, alloc_tag); end
        for (int i = 0; i < D; i++) alloc(5'(i));
        wback(5, 32'habc);
        checks++; if (retire_valid !== 1'b1 || retire_tag !== 5) begin errors++; $display("FAIL full_ret5 got v=%b t=%0d want 1/5", retire_valid, retire_tag); end
        alloc(5'd9);
        checks++; if (count !== D - 1 || alloc_tag !== 5) begin errors++; $display("FAIL full_nobypass got count=%0d tag=%0d want %0d/5", count, alloc_tag, D - 1); end
        alloc(5'd9);
        rd_tag1 = 5; #1;
        checks++; if (count !== D || rd_entry1.valid !== 1'b1 || rd_entry1.dest !== 5'd9 || rd_entry1.ready !== 1'b0)
            begin errors++; $display("FAIL refill5 got count=%0d entry=%h want %0d/valid dest 9", count, rd_entry1, D); end
        rd_tag1 = 6; #1;
        checks++; if (rd_entry1.valid !== 1'b1 || rd_entry1.dest !== 5'd1) begin errors++; $display("FAIL head6 got %h want valid dest 1", rd_entry1); end
    endtask

    task automatic test_bad_wb();
        step(1, 0, 0, 0, 5'd0, 0, 0, 32'h0);
        alloc(5'd7); alloc(5'd8);
        wback(0, 32'h11); wback(5, 32'h22); wback(17, 32'h33);
        for (int t = 1; t <= 2; t++) begin
            rd_tag1 = t; #1;
            checks++; if (rd_entry1 !== rob_entry'{valid: 1'b1, ready: 1'b0, regwr: 1'b1, dest: 5'(6 + t), value: 32'h0})
                begin errors++; $display("FAIL badwb_entry%0d got %h want untouched", t, rd_entry1); end
        end
        rd_tag1 = 5; #1;
        checks++; if (rd_entry1.valid !== 1'b0 || rd_entry1.ready !== 1'b0) begin errors++; $display("FAIL badwb_tag5 got %h want invalid", rd_entry1); end
        rd_tag1 = 0; #1;
        checks++; if (rd_entry1 !== '0) begin errors++; $display("FAIL rd_tag0 got %h want 0", rd_entry1); end
        rd_tag1 = 17; #1;
        checks++; if (rd_entry1 !== '0) begin errors++; $display("FAIL rd_tag17 got %h want 0", rd_entry1); end
        checks++; if (retire_valid !== 1'b0 || count !== 2) begin errors++; $display("FAIL badwb_state got v=%b count=%0d want 0/2", retire_valid, count); end
    endtask

    task automatic test_wrap();
        int        exp_ret;
        int        wt;
        bit        wrapped;
        int        prev_tag;
        MemoryWord v;
        step(1, 0, 0, 0, 5'd0, 0, 0, 32'h0);
        exp_ret = 1; wrapped = 0;
        for (int c = 0; c < 40; c++) begin
            wt = 0;
            foreach (q[i]) if (wt == 0 && !q[i].ready) wt = q[i].tag;
            v = $urandom;
            prev_tag = alloc_tag;
            step(0, 0, 1, 1'($urandom), 5'($urandom), wt != 0, wt, v);
            if (prev_tag == D && alloc_tag == 1) wrapped = 1;
            checks++; if (count !== q.size() || count > 2) begin errors++; $display("FAIL wrap_count c%0d got %0d want %0d", c, count, q.size()); end
            if (m_retire()) begin
                checks++; if (retire_valid !== 1'b1 || retire_tag !== exp_ret || retire_value !== q[0].value || retire_dest !== q[0].dest)
                    begin errors++; $display("FAIL wrap_ret c%0d got v=%b t=%0d val=%h want 1/%0d/%h", c, retire_valid, retire_tag, retire_value, exp_ret, q[0].value); end
                exp_ret = exp_ret % D + 1;
            end
        end
        checks++; if (!wrapped || exp_ret < 3) begin errors++; $display("FAIL wrap_seen got wrapped=%0d next_ret=%0d want wrap", wrapped, exp_ret); end
    endtask

    task automatic test_random();
        int wt;
        int k;
        step(1, 0, 0, 0, 5'd0, 0, 0, 32'h0);
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(3) == 0 || q.size() == 0) wt = $urandom_range(17);
            else wt = q[$urandom_range(q.size() - 1)].tag;
            step(0, 0, $urandom_range(2) != 0, 1'($urandom), 5'($urandom), $urandom_range(1) == 1, wt, $urandom);
            checks++; if (count !== q.size() || alloc_ready !== (q.size() < D) || alloc_tag !== next_tag)
                begin errors++; $display("FAIL rnd_state c%0d got count=%0d rdy=%b tag=%0d want %0d/%0d/%0d", c, count, alloc_ready, alloc_tag, q.size(), q.size() < D, next_tag); end
            checks++; if (retire_valid !== m_retire()) begin errors++; $display("FAIL rnd_rv c%0d got %b want %b", c, retire_valid, m_retire()); end
            if (m_retire()) begin
                checks++; if (retire_tag !== q[0].tag || retire_value !== q[0].value || retire_dest !== q[0].dest || retire_regwr !== q[0].regwr)
                    begin errors++; $display("FAIL rnd_ret c%0d got t=%0d val=%h want %0d/%h", c, retire_tag, retire_value, q[0].tag, q[0].value); end
            end else begin
                checks++; if (retire_tag !== 0 || retire_value !== '0) begin errors++; $display("FAIL rnd_idle c%0d got t=%0d val=%h want 0", c, retire_tag, retire_value); end
            end
            if (q.size() > 0) begin
                k = $urandom_range(q.size() - 1);
                rd_tag1 = q[k].tag; #1;
                checks++; if (rd_entry1 !== rob_entry'{valid: 1'b1, ready: q[k].ready, regwr: q[k].regwr, dest: q[k].dest, value: q[k].value})
                    begin errors++; $display("FAIL rnd_rd c%0d tag %0d got %h", c, q[k].tag, rd_entry1); end
            end
        end
    endtask

`ifdef ROB_FLUSH_EN
    task automatic test_flush();
        step(1, 0, 0, 0, 5'd0, 0, 0, 32'h0);
        for (int i = 0; i < 5; i++) alloc(5'(i));
        wback(1, 32'h77);
        flush = 1'b1; #1;
        checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL flush_rv_comb got %b want 0", retire_valid); end
        step(0, 1, 1, 1, 5'd4, 1, 2, 32'h99);
        checks++; if (count !== 0 || alloc_tag !== 1 || retire_valid !== 1'b0)
            begin errors++; $display("FAIL flush got count=%0d tag=%0d v=%b want 0/1/0", count, alloc_tag, retire_valid); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_wb_order();
        test_full_alloc_retire();
        test_bad_wb();
        test_wrap();
        test_random();
`ifdef ROB_FLUSH_EN
        test_flush();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
